// File: rtl/decoder_line_monitor.sv
// Snapshots the 16 decoder lines on request, classifies them as none/one-hot/multi-hot,
// and presents the result over valid/ready. Optional sticky flag: DECODER_LINE_MONITOR_STICKY_ERR_EN.
module decoder_line_monitor #(
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      lines,
   input  logic             sample,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [3:0]       out_index,
   output logic [1:0]       out_kind,
   output logic [ERR_W-1:0] err_count,
   output logic             busy,
   output logic             err_sticky
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EVAL = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   localparam logic [1:0] K_NONE  = 2'b00;
   localparam logic [1:0] K_ONE   = 2'b01;
   localparam logic [1:0] K_MULTI = 2'b10;

   logic [1:0]  state;
   logic [15:0] snap;
   logic [1:0]  eval_kind;
   logic [3:0]  eval_index;
   logic        transfer;

   function automatic logic [1:0] classify(input logic [15:0] v);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
      if (n == 5'd0)      return K_NONE;
      else if (n == 5'd1) return K_ONE;
      else                return K_MULTI;
   endfunction

   // Scanning downward leaves the lowest set position as the final assignment.
   function automatic logic [3:0] lowest_index(input logic [15:0] v);
      logic [3:0] idx;
      idx = '0;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
      return (c == '1) ? c : c + ERR_W'(1);
   endfunction

   assign eval_kind  = classify(snap);
   assign eval_index = lowest_index(snap);
   assign out_valid  = (state == S_HOLD);
   assign busy       = (state != S_IDLE);
   assign transfer   = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         snap      <= '0;
         out_index <= '0;
         out_kind  <= K_NONE;
         err_count <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (sample) begin
                  snap  <= lines;
                  state <= S_EVAL;
               end
            end
            S_EVAL: begin
               out_kind  <= eval_kind;
               out_index <= eval_index;
               if (eval_kind != K_ONE) err_count <= sat_inc(err_count);
               state <= S_HOLD;
            end
            S_HOLD: begin
               // Samples arriving while stalled are dropped, not queued.
               if (transfer) begin
                  if (sample) begin
                     snap  <= lines;
                     state <= S_EVAL;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef DECODER_LINE_MONITOR_STICKY_ERR_EN
   always_ff @(posedge clk) begin
      if (rst)
         err_sticky <= 1'b0;
      else if ((state == S_EVAL) && (eval_kind != K_ONE))
         err_sticky <= 1'b1;
   end
`else
   assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_line_monitor.sv
// Self-checking bench for decoder_line_monitor: directed vector table, hand-written
// corner sequences, and randomized traffic against a transaction-level reference model.
module tb_decoder_line_monitor;

   localparam int ERR_W   = 2;
   localparam int ERR_MAX = (1 << ERR_W) - 1;

   logic             clk;
   logic             rst;
   logic [15:0]      lines;
   logic             sample;
   logic             out_ready;
   logic             out_valid;
   logic [3:0]       out_index;
   logic [1:0]       out_kind;
   logic [ERR_W-1:0] err_count;
   logic             busy;
   logic             err_sticky;

   decoder_line_monitor #(.ERR_W(ERR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .lines      (lines),
      .sample     (sample),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_index  (out_index),
      .out_kind   (out_kind),
      .err_count  (err_count),
      .busy       (busy),
      .err_sticky (err_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: a capture becomes a result one cycle later, which is then
   // offered until a transfer takes it away.
   bit          m_have_capture;
   bit          m_presenting;
   logic [15:0] m_captured;
   int          m_index;
   int          m_kind;
   int          m_err;
   bit          m_sticky;

   typedef struct {
      logic [15:0] lines;
      int          index;
      int          kind;
      int          err;
   } vec_t;

   vec_t vecs[18];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int ref_kind(input logic [15:0] v);
      int n = $countones(v);
      return (n == 0) ? 0 : ((n == 1) ? 1 : 2);
   endfunction

   function automatic int ref_index(input logic [15:0] v);
      for (int k = 0; k < 16; k++) if (v[k]) return k;
      return 0;
   endfunction

   task automatic model_edge(input bit r, input bit s, input bit rdy, input logic [15:0] l);
      if (r) begin
         m_have_capture = 0; m_presenting = 0; m_captured = '0;
         m_index = 0; m_kind = 0; m_err = 0; m_sticky = 0;
      end else if (m_have_capture) begin
         m_have_capture = 0;
         m_presenting   = 1;
         m_kind  = ref_kind(m_captured);
         m_index = ref_index(m_captured);
         if (m_kind != 1) begin
            if (m_err < ERR_MAX) m_err++;
            m_sticky = 1;
         end
      end else if (m_presenting) begin
         if (rdy) begin
            m_presenting = 0;
            if (s) begin m_captured = l; m_have_capture = 1; end
         end
      end else if (s) begin
         m_captured = l;
         m_have_capture = 1;
      end
   endtask

   task automatic compare_all();
      chk("out_valid", int'(out_valid), int'(m_presenting));
      chk("busy", int'(busy), int'(m_presenting | m_have_capture));
      chk("out_index", int'(out_index), m_index);
      chk("out_kind", int'(out_kind), m_kind);
      chk("err_count", int'(err_count), m_err);
`ifdef DECODER_LINE_MONITOR_STICKY_ERR_EN
      chk("err_sticky", int'(err_sticky), int'(m_sticky));
`else
      chk("err_sticky", int'(err_sticky), 0);
`endif
   endtask

   task automatic step(input bit r, input bit s, input bit rdy, input logic [15:0] l);
      rst = r; sample = s; out_ready = rdy; lines = l;
      @(posedge clk);
      model_edge(r, s, rdy, l);
      #1;
      compare_all();
   endtask

   function automatic logic [15:0] rand_lines();
      logic [15:0] v;
      case ($urandom_range(0, 3))
         0:       v = 16'h0000;
         1:       v = 16'h0001 << $urandom_range(0, 15);
         2:       v = 16'($urandom);
         default: v = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      endcase
      return v;
   endfunction

   initial begin
      rst = 1'b1; sample = 1'b0; out_ready = 1'b0; lines = '0;

      for (int i = 0; i < 16; i++) vecs[i] = '{16'h0001 << i, i, 1, 0};
      vecs[16] = '{16'h0000, 0, 0, 1};
      vecs[17] = '{16'h0120, 5, 2, 2};

      // Reset with aggressive inputs
      step(1, 1, 1, 16'hFFFF);
      step(1, 1, 1, 16'hFFFF);
      chk("reset_valid", int'(out_valid), 0);
      chk("reset_busy", int'(busy), 0);
      step(0, 0, 0, 16'h0000);

      // Directed table: capture, result at k+2, then transfer
      for (int i = 0; i < 18; i++) begin
         step(0, 1, 1, vecs[i].lines);
         step(0, 0, 1, 16'h0000);
         chk($sformatf("vec%0d_valid", i), int'(out_valid), 1);
         chk($sformatf("vec%0d_index", i), int'(out_index), vecs[i].index);
         chk($sformatf("vec%0d_kind", i), int'(out_kind), vecs[i].kind);
         chk($sformatf("vec%0d_err", i), int'(err_count), vecs[i].err);
         step(0, 0, 1, 16'h0000);
      end
`ifdef DECODER_LINE_MONITOR_STICKY_ERR_EN
      chk("sticky_after_errors", int'(err_sticky), 1);
`else
      chk("sticky_after_errors", int'(err_sticky), 0);
`endif

      // Backpressure with a dropped sample during the stall
      step(0, 1, 0, 16'h8000);
      step(0, 0, 0, 16'h0000);
      for (int i = 0; i < 5; i++) begin
         step(0, (i % 2) == 0, 0, 16'h0003 << i);
         chk("stall_valid", int'(out_valid), 1);
         chk("stall_index", int'(out_index), 15);
      end
      step(0, 0, 1, 16'h0000);
      chk("stall_released", int'(out_valid), 0);
      step(0, 0, 1, 16'h0000);
      chk("no_extra_result", int'(out_valid), 0);
      chk("no_extra_busy", int'(busy), 0);

      // Back-to-back: one result every two cycles, alternating lines
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 1, (((i / 2) % 2) != 0) ? 16'h0400 : 16'h0004);
         if ((i % 2) == 1) begin
            chk("b2b_valid", int'(out_valid), 1);
            chk("b2b_index", int'(out_index), (((i / 2) % 2) != 0) ? 10 : 2);
         end else if (i > 0) begin
            chk("b2b_gap", int'(out_valid), 0);
         end
      end
      step(0, 0, 1, 16'h0000);
      step(0, 0, 1, 16'h0000);

      // Saturation, then reset while holding a result
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 1, 16'h0003);
         step(0, 0, 1, 16'h0000);
         step(0, 0, 1, 16'h0000);
      end
      chk("saturated", int'(err_count), ERR_MAX);
      step(0, 1, 0, 16'h0003);
      step(0, 0, 0, 16'h0000);
      chk("hold_before_rst", int'(out_valid), 1);
      step(1, 0, 0, 16'h0000);
      chk("rst_in_hold_valid", int'(out_valid), 0);
      chk("rst_in_hold_err", int'(err_count), 0);
      step(0, 0, 0, 16'h0000);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 3) != 0), rand_lines());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
